// File: rtl/adc_pkg.sv
// Shared field layout and types for AD7928 conversion words.
package adc_pkg;
    localparam int ADC_DATA_W  = 12;
    localparam int ADC_CH_W    = 3;
    localparam int ADC_WORD_W  = 16;
    localparam int ADC_CH_MSB  = 14;
    localparam int ADC_CH_LSB  = 12;
    localparam int ADC_FMT_BIT = 15;
    localparam int ADC_NCH     = 1 << ADC_CH_W;

    typedef logic [ADC_CH_W-1:0]   adc_ch_t;
    typedef logic [ADC_DATA_W-1:0] adc_code_t;

    function automatic adc_ch_t adc_word_ch(input logic [ADC_WORD_W-1:0] w);
        return w[ADC_CH_MSB:ADC_CH_LSB];
    endfunction
endpackage

// File: rtl/adc_seq_chk.sv
// Tracks the expected next channel of the 0..7 round-robin and flags breaks.
module adc_seq_chk
    import adc_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  adc_ch_t ch,
    input  logic    vld,
    input  logic    clr,
    output logic    seq_err
);
    logic    synced;
    adc_ch_t exp_ch;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            synced  <= 1'b0;
            exp_ch  <= '0;
            seq_err <= 1'b0;
        end else if (vld) begin
            // Always resync to the observed channel so one glitch flags once.
            if (synced && ch != exp_ch)
                seq_err <= 1'b1;
            synced <= 1'b1;
            exp_ch <= ch + adc_ch_t'(1);
        end
    end
endmodule

// File: rtl/adc_ch_avg8.sv
// Per-channel boxcar averager for AD7928 words with a readable result table.
module adc_ch_avg8
    import adc_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADC_WORD_W-1:0] din,
    input  logic                  din_vld,
    input  logic                  clr,
    output logic [ADC_DATA_W-1:0] avg_dout,
    output logic [ADC_CH_W-1:0]   avg_ch,
    output logic                  avg_vld,
    input  logic [ADC_CH_W-1:0]   rd_ch,
    output logic [ADC_DATA_W-1:0] rd_data,
    output logic                  seq_err,
    output logic                  fmt_err
);
    localparam int NCH   = ADC_NCH;
    localparam int ACC_W = ADC_DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WIN   = 1 << AVG_LOG2;

    logic [ACC_W-1:0]      acc [NCH];
    logic [CNT_W-1:0]      cnt [NCH];
    logic [ADC_DATA_W-1:0] tbl [NCH];

    adc_ch_t          ch;
    adc_code_t        s;
    logic             fmt_bad;
    logic             take;
    logic [ACC_W-1:0] sum;
    logic             win_done;

    assign ch       = adc_word_ch(din);
    assign s        = din[ADC_DATA_W-1:0];
    assign fmt_bad  = din[ADC_FMT_BIT];
    assign take     = din_vld && !clr && !fmt_bad;
    assign sum      = acc[ch] + ACC_W'(s);
    assign win_done = (cnt[ch] == CNT_W'(WIN - 1));

    adc_seq_chk u_seq_chk (
        .clk     (clk),
        .rst     (rst),
        .ch      (ch),
        .vld     (take),
        .clr     (clr),
        .seq_err (seq_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
                tbl[i] <= '0;
            end
            avg_dout <= '0;
            avg_ch   <= '0;
            avg_vld  <= 1'b0;
            rd_data  <= '0;
            fmt_err  <= 1'b0;
        end else begin
            avg_vld <= 1'b0;
            // Nonblocking read gives old-value semantics on a same-cycle write.
            rd_data <= tbl[rd_ch];
            if (clr) begin
                for (int i = 0; i < NCH; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
                fmt_err <= 1'b0;
            end else if (din_vld) begin
                if (fmt_bad) begin
                    fmt_err <= 1'b1;
                end else if (win_done) begin
                    avg_dout <= sum[ACC_W-1:AVG_LOG2];
                    avg_ch   <= ch;
                    avg_vld  <= 1'b1;
                    tbl[ch]  <= sum[ACC_W-1:AVG_LOG2];
                    acc[ch]  <= '0;
                    cnt[ch]  <= '0;
                end else begin
                    acc[ch] <= sum;
                    cnt[ch] <= cnt[ch] + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_ch_avg8.sv
// Directed checks of adc_ch_avg8 at AVG_LOG2=2 and AVG_LOG2=0 (shared stimulus).
module tb_adc_ch_avg8;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_vld;
    logic        clr;
    logic [2:0]  rd_ch;

    logic [11:0] a2_dout, a2_rd, a0_dout, a0_rd;
    logic [2:0]  a2_ch, a0_ch;
    logic        a2_vld, a2_seq, a2_fmt, a0_vld, a0_seq, a0_fmt;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    adc_ch_avg8 #(.AVG_LOG2(2)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .avg_dout(a2_dout), .avg_ch(a2_ch), .avg_vld(a2_vld),
        .rd_ch(rd_ch), .rd_data(a2_rd), .seq_err(a2_seq), .fmt_err(a2_fmt)
    );

    adc_ch_avg8 #(.AVG_LOG2(0)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
        .avg_dout(a0_dout), .avg_ch(a0_ch), .avg_vld(a0_vld),
        .rd_ch(rd_ch), .rd_data(a0_rd), .seq_err(a0_seq), .fmt_err(a0_fmt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] ch, input logic [11:0] code);
        din     = {1'b0, ch, code};
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; din = '0; din_vld = 1'b0; clr = 1'b0; rd_ch = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_vld",  a2_vld,  0);
        chk("rst_dout", a2_dout, 0);
        chk("rst_seq",  a2_seq,  0);
        chk("rst_fmt",  a2_fmt,  0);
        chk("rst_rd",   a2_rd,   0);

        // One ch0 window: (100+101+102+105)/4 = 102
        send(0, 100); chk("w1_s1_vld", a2_vld, 0);
        chk("p0_dout", a0_dout, 100); chk("p0_vld", a0_vld, 1);
        send(0, 101); chk("w1_s2_vld", a2_vld, 0);
        send(0, 102); chk("w1_s3_vld", a2_vld, 0);
        send(0, 105);
        chk("w1_vld", a2_vld, 1); chk("w1_ch", a2_ch, 0); chk("w1_dout", a2_dout, 102);
        tick();
        chk("w1_vld_off", a2_vld, 0); chk("w1_hold", a2_dout, 102);
        do_clr();
        chk("clr_seq", a2_seq, 0); chk("clr_keep_dout", a2_dout, 102);

        // Round robin, 4 passes, back to back
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 8; k++) begin
                send(3'(k), 12'(500 * k));
                if (p < 3) chk($sformatf("rr_p%0d_ch%0d_vld", p, k), a2_vld, 0);
                else begin
                    chk($sformatf("rr_ch%0d_vld", k), a2_vld, 1);
                    chk($sformatf("rr_ch%0d_ch", k), a2_ch, k);
                    chk($sformatf("rr_ch%0d_dout", k), a2_dout, 500 * k);
                end
            end
        end
        chk("rr_seq", a2_seq, 0);
        for (int k = 0; k < 8; k++) begin
            rd_ch = 3'(k);
            tick();
            chk($sformatf("rr_rd%0d", k), a2_rd, 500 * k);
        end

        // Sequence break
        do_clr();
        send(0, 10);
        send(1, 10); chk("seq_ok", a2_seq, 0);
        send(3, 10); chk("seq_break", a2_seq, 1);
        send(4, 10); send(5, 10); chk("seq_sticky", a2_seq, 1);
        do_clr(); chk("seq_clr", a2_seq, 0);
        send(6, 10); chk("seq_after_clr", a2_seq, 0);

        // Format error: bad word must not accumulate or touch the tracker
        do_clr();
        send(0, 40);
        din = 16'h8ABC; din_vld = 1'b1; tick(); din_vld = 1'b0;
        chk("fmt_set", a2_fmt, 1); chk("fmt_no_vld", a2_vld, 0); chk("fmt_no_vld0", a0_vld, 0);
        send(1, 0); chk("fmt_seq_kept", a2_seq, 0);
        send(0, 44); send(0, 48); chk("fmt_w_early", a2_vld, 0);
        send(0, 52);
        chk("fmt_w_vld", a2_vld, 1); chk("fmt_w_dout", a2_dout, 46); chk("fmt_sticky", a2_fmt, 1);

        // Pass-through read-during-write on ch2 (table held 1000 from round robin)
        rd_ch = 3'd2;
        tick();
        chk("pt_rd_pre", a0_rd, 1000);
        send(2, 12'hFFF);
        chk("pt_vld", a0_vld, 1); chk("pt_dout", a0_dout, 12'hFFF); chk("pt_rd_old", a0_rd, 1000);
        tick();
        chk("pt_rd_new", a0_rd, 12'hFFF);

        // Reset mid-window on ch5
        do_clr();
        send(5, 100); send(5, 100);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mr_dout", a2_dout, 0); chk("mr_ch", a2_ch, 0); chk("mr_vld", a2_vld, 0);
        chk("mr_seq", a2_seq, 0); chk("mr_fmt", a2_fmt, 0); chk("mr_rd", a2_rd, 0);
        send(5, 8); send(5, 8); chk("mr_partial_lost", a2_vld, 0);
        send(5, 8); send(5, 8);
        chk("mr_vld", a2_vld, 1); chk("mr_ch5", a2_ch, 5); chk("mr_avg", a2_dout, 8);

        // clr with din_vld discards the word
        din = {1'b0, 3'd5, 12'd8}; din_vld = 1'b1; clr = 1'b1;
        tick();
        din_vld = 1'b0; clr = 1'b0;
        chk("cd_vld", a2_vld, 0);
        send(5, 8); send(5, 8); send(5, 8); chk("cd_dropped", a2_vld, 0);
        send(5, 8); chk("cd_vld4", a2_vld, 1); chk("cd_avg", a2_dout, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_ch_avg8.md
Name: adc_ch_avg8

Overview:
- Consumes 16-bit conversion words and their valid strobe from the AD7928 8-channel sequencer.
- Demultiplexes each word by its embedded channel address and keeps a per-channel boxcar average over 2^AVG_LOG2 samples.
- Emits one averaged, channel-tagged result per completed window.
- Keeps a readable table of the latest averages, and flags channel-sequence and word-format errors for the downstream display/UART logic.

Parameters:
- AVG_LOG2, 4, log2 of samples per average window; legal range 0..6 (0 = pass-through).
- NCH, 8, number of channels; fixed at 8 because the address field is 3 bits. Not for override.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous, active-high reset
- din  input  16  ADC word: [15] leading zero, [14:12] channel address, [11:0] straight-binary code
- din_vld  input  1  one-cycle strobe; din valid this cycle
- clr  input  1  synchronous clear of accumulators, counters, error flags and sequence tracker
- avg_dout  output  12  averaged code of the completed window
- avg_ch  output  3  channel of avg_dout
- avg_vld  output  1  one-cycle strobe for avg_dout/avg_ch
- rd_ch  input  3  table read address
- rd_data  output  12  latest average for rd_ch, registered
- seq_err  output  1  sticky: channel order broke from 0..7 round-robin
- fmt_err  output  1  sticky: word arrived with din[15]=1

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0; accumulators, window counters and table entries 0; sequence tracker unsynced.
- Accept condition: din_vld=1 and clr=0.
  - If din[15]=1: word is dropped (no accumulate, no sequence update) and fmt_err<=1.
- Accumulate, for accepted word, ch=din[14:12], s=din[11:0]:
  - acc[ch] is 12+AVG_LOG2 bits and cnt[ch] is AVG_LOG2 bits; no overflow is possible.
  - If cnt[ch] < 2^AVG_LOG2-1: acc[ch] <= acc[ch]+s and cnt[ch] <= cnt[ch]+1.
  - Else (window complete):
    - avg_dout <= (acc[ch]+s)>>AVG_LOG2 (truncate, no rounding); avg_ch <= ch; avg_vld <= 1.
    - table[ch] <= same value; acc[ch] <= 0; cnt[ch] <= 0.
- Latency: avg_vld asserts exactly 1 cycle after the accepting din_vld and stays high for 1 cycle. avg_dout/avg_ch hold until the next avg_vld.
- AVG_LOG2=0: every accepted word produces avg_vld with avg_dout=s.
- Back-to-back din_vld on consecutive cycles, any channel mix, is fully supported. No backpressure and no input buffering.
- Sequence tracker:
  - First accepted word after rst or clr: sets exp_ch <= ch+1 (mod 8), no error.
  - Later words: if ch != exp_ch then seq_err <= 1. In all cases exp_ch <= ch+1 (resync); the word is still accumulated.
- Read port:
  - rd_data <= table[rd_ch] every cycle (1-cycle latency).
  - If the addressed entry is written in the same cycle, rd_data returns the old value; the new value appears on the next cycle.
- clr:
  - Zeroes all acc/cnt, seq_err, fmt_err and the sequence tracker.
  - Table contents and avg_dout/avg_ch are preserved; avg_vld <= 0.
  - clr with din_vld in the same cycle: clr wins and the word is discarded.
- rst mid-window: everything returns to reset values, including the table. Partial windows are lost.
- Errors stay set until rst or clr; there is no other clear path.

Decomposition:
- Shared package adc_pkg:
  - ADC_DATA_W=12, ADC_CH_W=3, ADC_WORD_W=16.
  - Field positions ADC_CH_MSB=14, ADC_CH_LSB=12, ADC_FMT_BIT=15.
- One sub-module, adc_seq_chk: exp_ch tracking and seq_err generation, with inputs ch, vld, clr.
- Accumulator and table arrays stay in the top module.

Test Plan:
- AVG_LOG2=2; feed ch0 codes 100,101,102,105 → one avg_vld 1 cycle after the 4th strobe, avg_ch=0, avg_dout=102; no strobe after the first three.
- AVG_LOG2=2; round-robin ch0..7 × 4 passes, ch k code = 500·k, on back-to-back cycles → eight avg_vld in order ch0..7 with avg_dout=500·k; table reads via rd_ch match; seq_err=0.
- Sequence ch0,1,3 → seq_err=1 on the cycle after ch3; continue 4,5 → stays 1; assert clr → 0; next ch6 is accepted without error.
- din=16'h8ABC with din_vld → fmt_err=1; no accumulation (the following window still averages correctly); seq state unchanged.
- AVG_LOG2=0, rd_ch=2; ch2 code 0xFFF → avg_dout=0xFFF; rd_data shows the old value that cycle and 0xFFF the next.
- Mid-window (2 of 4 samples on ch5), assert rst for 1 cycle → all outputs 0; 4 new ch5 samples of 8 → avg_dout=8 (the old partial sum is discarded); clr together with din_vld drops the sample.
